btb_predictor: RTL and testbench

Branch target buffer and 2-bit direction predictor for the 5-stage core. It answers the fetch stage's per-cycle "predicted taken / predicted target" lookup, which travels down the pipe as the execute stage's predictedTaken input. It also absorbs the execute stage's resolved-outcome update, qualified by update_btb. A sequenced invalidate walk clears the table on fence.i or software request without a pipeline-wide reset.

---
 rtl/btb_predictor.sv | 116 +++++++++++
 tb/tb_btb_predictor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - branch target buffer with 2-bit direction counters and invalidate walk
module btb_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_update,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        flush_req,
  output logic        busy,
  output logic        flush_done
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  typedef enum logic {S_IDLE, S_WALK} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   walk_cnt;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr    [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];

  // PC bits [1:0] never select an entry; fold them into a sink
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;

  assign l_idx = if_pc[IDX_W+1:2];
  assign l_tag = if_pc[31:IDX_W+2];
  assign u_idx = ex_pc[IDX_W+1:2];
  assign u_tag = ex_pc[31:IDX_W+2];
  assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

  // Lookup is purely combinational; the table reads its pre-edge contents
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    if (l_hit && ctr[l_idx][1] && !busy) begin
      pred_taken  = 1'b1;
      pred_target = target[l_idx];
    end
  end

  // State register, walk counter and the registered completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      walk_cnt   <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      walk_cnt   <= (state == S_WALK) ? walk_cnt + 1'b1 : '0;
      flush_done <= (state == S_WALK) && (walk_cnt == LAST_IDX);
    end
  end

  // Next state: a walk always runs to the last entry once started
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (flush_req) state_nxt = S_WALK;
      S_WALK: if (walk_cnt == LAST_IDX) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    if (state == S_WALK) busy = 1'b1;
  end

  // Valid bits and direction counters: walk clear has priority over updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (busy) begin
      valid[walk_cnt] <= 1'b0;
      ctr[walk_cnt]   <= 2'b01;
    end else if (ex_update) begin
      if (u_hit) begin
        if (ex_taken && ctr[u_idx] != 2'b11)
          ctr[u_idx] <= ctr[u_idx] + 2'b01;
        else if (!ex_taken && ctr[u_idx] != 2'b00)
          ctr[u_idx] <= ctr[u_idx] - 2'b01;
      end else if (ex_taken) begin
        valid[u_idx] <= 1'b1;
        ctr[u_idx]   <= 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; they are only meaningful under valid
  always_ff @(posedge clk) begin
    if (!busy && ex_update && ex_taken) begin
      target[u_idx] <= ex_target;
      if (!u_hit) tag[u_idx] <= u_tag;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - directed vector bench for btb_predictor
module tb_btb_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_update;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush_req;
  logic        busy;
  logic        flush_done;

  int checks;
  int failures;

  btb_predictor #(.ENTRIES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_pc      (if_pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .ex_update  (ex_update),
    .ex_pc      (ex_pc),
    .ex_taken   (ex_taken),
    .ex_target  (ex_target),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        upd;
    logic [31:0] upc;
    logic        utk;
    logic [31:0] utgt;
    logic [31:0] lpc;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input string name, input logic upd, input logic [31:0] upc,
                      input logic utk, input logic [31:0] utgt, input logic [31:0] lpc,
                      input logic et, input logic [31:0] etgt);
    vec_t v;
    v.name = name; v.upd = upd; v.upc = upc; v.utk = utk; v.utgt = utgt;
    v.lpc = lpc; v.exp_taken = et; v.exp_target = etgt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    ex_update = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    step();
    ex_update = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic et,
                        input logic [31:0] etgt);
    if_pc = pc;
    #1;
    chk({name, "_taken"}, {31'h0, pred_taken}, {31'h0, et});
    chk({name, "_target"}, pred_target, etgt);
  endtask

  // Pulses flush_req, then observes 40 cycles; optional mid-walk disturbances
  task automatic run_walk(input bit disturb, output int n_busy, output int n_done,
                          output int done_cyc);
    n_busy = 0; n_done = 0; done_cyc = -1;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (busy) n_busy++;
      if (flush_done) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_low_at_done", {31'h0, busy}, 32'h0);
      end
      if (disturb && cyc == 2) begin
        if_pc = 32'h140;
        #1;
        chk("walk_lookup_suppressed", {31'h0, pred_taken}, 32'h0);
      end
      if (disturb && cyc == 4) begin
        ex_update = 1'b1; ex_pc = 32'h180; ex_taken = 1'b1; ex_target = 32'h600;
      end
      if (disturb && cyc == 6) flush_req = 1'b1;
      step();
      ex_update = 1'b0;
      flush_req = 1'b0;
    end
  endtask

  int nb, nd, dc;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; if_pc = 32'h0; ex_update = 1'b0; ex_pc = 32'h0;
    ex_taken = 1'b0; ex_target = 32'h0; flush_req = 1'b0;
    #12;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, flush_done}, 32'h0);
    rst_n = 1'b1;
    step();

    // Lookup is sampled before each vector's edge, so it shows prior vectors' effect
    addv("v00_reset_lookup",   0, 32'h0,        0, 32'h0,        32'h100,  0, 32'h0);
    addv("v01_alloc_same_cyc", 1, 32'h100,      1, 32'h200,      32'h100,  0, 32'h0);
    addv("v02_alloc_hit",      0, 32'h0,        0, 32'h0,        32'h100,  1, 32'h200);
    addv("v03_nt_from10",      1, 32'h100,      0, 32'h999,      32'h100,  1, 32'h200);
    addv("v04_nt_from01",      1, 32'h100,      0, 32'h999,      32'h100,  0, 32'h0);
    addv("v05_ctr00",          1, 32'h100,      0, 32'h999,      32'h100,  0, 32'h0);
    addv("v06_t_from00",       1, 32'h100,      1, 32'h200,      32'h100,  0, 32'h0);
    addv("v07_t_from01",       1, 32'h100,      1, 32'h200,      32'h100,  0, 32'h0);
    addv("v08_t_from10",       1, 32'h100,      1, 32'h204,      32'h100,  1, 32'h200);
    addv("v09_t_sat11",        1, 32'h100,      1, 32'h208,      32'h100,  1, 32'h204);
    addv("v10_nt_from11",      1, 32'h100,      0, 32'h999,      32'h100,  1, 32'h208);
    addv("v11_ctr10",          0, 32'h0,        0, 32'h0,        32'h100,  1, 32'h208);
    addv("v12_alias_miss",     1, 32'h140,      0, 32'h999,      32'h140,  0, 32'h0);
    addv("v13_alias_nt_nochg", 0, 32'h0,        0, 32'h0,        32'h100,  1, 32'h208);
    addv("v14_alias_alloc",    1, 32'h140,      1, 32'h400,      32'h100,  1, 32'h208);
    addv("v15_alias_hit",      0, 32'h0,        0, 32'h0,        32'h140,  1, 32'h400);
    addv("v16_orig_evicted",   0, 32'h0,        0, 32'h0,        32'h100,  0, 32'h0);
    addv("v17_idx1_alloc",     1, 32'h1004,     1, 32'h500,      32'h1006, 0, 32'h0);
    addv("v18_idx1_lowbits",   0, 32'h0,        0, 32'h0,        32'h1006, 1, 32'h500);
    addv("v19_idx15_alloc",    1, 32'hFFFFFFFC, 1, 32'h12345678, 32'hFFFFFFFC, 0, 32'h0);
    addv("v20_idx15_hit",      0, 32'h0,        0, 32'h0,        32'hFFFFFFFC, 1, 32'h12345678);
    addv("v21_idx15_tag0",     0, 32'h0,        0, 32'h0,        32'h3C,   0, 32'h0);

    foreach (vq[i]) begin
      if_pc = vq[i].lpc;
      ex_update = vq[i].upd; ex_pc = vq[i].upc;
      ex_taken = vq[i].utk; ex_target = vq[i].utgt;
      #1;
      chk({vq[i].name, "_taken"}, {31'h0, pred_taken}, {31'h0, vq[i].exp_taken});
      chk({vq[i].name, "_target"}, pred_target, vq[i].exp_target);
      chk({vq[i].name, "_busy"}, {31'h0, busy}, 32'h0);
      step();
    end
    ex_update = 1'b0;

    // Walk with mid-walk update, lookup and ignored flush_req
    run_walk(1'b1, nb, nd, dc);
    chk("walk1_busy_cycles", nb, 16);
    chk("walk1_done_pulses", nd, 1);
    chk("walk1_done_cycle", dc, 16);
    lookup("post_walk_140", 32'h140, 0, 32'h0);
    lookup("post_walk_1004", 32'h1004, 0, 32'h0);
    lookup("post_walk_fffc", 32'hFFFFFFFC, 0, 32'h0);
    lookup("post_walk_180", 32'h180, 0, 32'h0);
    do_update(32'h140, 1'b1, 32'h700);
    lookup("realloc_140", 32'h140, 1, 32'h700);

    // Update and flush_req on the same idle edge: walk wipes the update
    ex_update = 1'b1; ex_pc = 32'h1004; ex_taken = 1'b1; ex_target = 32'h500;
    run_walk(1'b0, nb, nd, dc);
    chk("walk2_busy_cycles", nb, 16);
    chk("walk2_done_pulses", nd, 1);
    lookup("same_edge_1004", 32'h1004, 0, 32'h0);
    lookup("same_edge_140", 32'h140, 0, 32'h0);

    // Reset in the middle of a walk
    do_update(32'hFFFFFFFC, 1'b1, 32'h800);
    lookup("pre_reset_fffc", 32'hFFFFFFFC, 1, 32'h800);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("walk3_busy_start", {31'h0, busy}, 32'h1);
    for (int k = 0; k < 4; k++) step();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_busy", {31'h0, busy}, 32'h0);
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (flush_done) nd++;
      if (busy) nd++;
      step();
    end
    chk("reset_mid_no_done", nd, 0);
    lookup("reset_mid_fffc", 32'hFFFFFFFC, 0, 32'h0);
    run_walk(1'b0, nb, nd, dc);
    chk("walk4_busy_cycles", nb, 16);
    chk("walk4_done_pulses", nd, 1);
    chk("walk4_done_cycle", dc, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
